// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory responder.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // log2 of the word size in bytes; address bits below this must be zero
  localparam int unsigned DMEM_ADDR_ALIGN = 2;
  localparam int unsigned DMEM_WORD_W     = 32;
  localparam int unsigned DMEM_BE_W       = DMEM_WORD_W / 8;
  localparam int unsigned DMEM_CNT_W      = 4;

  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic [DMEM_WORD_W-1:0] addr;
    logic [DMEM_WORD_W-1:0] dat;
    logic [DMEM_BE_W-1:0]   be;
  } dmem_req_t;

  function automatic logic addr_misaligned(input logic [DMEM_WORD_W-1:0] a);
    return |a[DMEM_ADDR_ALIGN-1:0];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-lane synchronous write, combinational read.
module dmem_array
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DMEM_WORD_W-1:0] wr_dat,
  input  logic [DMEM_BE_W-1:0]   be,
  output logic [DMEM_WORD_W-1:0] rd_dat
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(DMEM_BE_W); i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  assign rd_dat = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: captures one request, inserts
// WAIT_CYCLES wait states, then pulses ready with data/err.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DMEM_WORD_W-1:0] m_addr,
  input  logic [DMEM_WORD_W-1:0] m_wr_dat,
  input  logic [DMEM_BE_W-1:0]   byte_en,
  output logic [DMEM_WORD_W-1:0] m_rd_dat,
  output logic                   ready,
  output logic                   err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_e            state;
  logic [DMEM_CNT_W-1:0]  cnt;
  dmem_req_t              cap;
  dmem_req_t              acc_c;
  logic                   req_c;
  logic                   enter_resp_c;
  logic                   acc_err_c;
  logic                   wr_fire_c;
  logic [DMEM_WORD_W-1:0] off_c;
  logic [29:0]            word_c;
  logic [IDX_W-1:0]       idx_c;
  logic [DMEM_WORD_W-1:0] rd_word_c;

  assign req_c = rd_en | wr_en;

  // Live inputs while idle (needed for the zero-wait path), captured copy otherwise
  always_comb begin
    acc_c = cap;
    if (state == IDLE) begin
      acc_c.rd   = rd_en;
      acc_c.wr   = wr_en;
      acc_c.addr = m_addr;
      acc_c.dat  = m_wr_dat;
      acc_c.be   = byte_en;
    end
  end

  assign off_c     = acc_c.addr - BASE_ADDR;
  assign word_c    = 30'(off_c >> DMEM_ADDR_ALIGN);
  assign idx_c     = word_c[IDX_W-1:0];
  assign acc_err_c = addr_misaligned(acc_c.addr)
                   | ({2'b00, word_c} >= 32'(DEPTH_WORDS))
                   | (acc_c.rd & acc_c.wr);

  assign enter_resp_c = ((state == IDLE) && req_c && (WAIT_CYCLES == 0))
                      || ((state == WAIT) && (cnt == DMEM_CNT_W'(1)));
  assign wr_fire_c    = enter_resp_c & acc_c.wr & ~acc_err_c;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_fire_c),
    .idx   (idx_c),
    .wr_dat(acc_c.dat),
    .be    (acc_c.be),
    .rd_dat(rd_word_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cap      <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      m_rd_dat <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_c) begin
            cap   <= acc_c;
            cnt   <= DMEM_CNT_W'(WAIT_CYCLES);
            state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - DMEM_CNT_W'(1);
          if (cnt == DMEM_CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Response is registered on the edge that enters RESP
      if (enter_resp_c) begin
        ready <= 1'b1;
        err   <= acc_err_c;
        if (acc_err_c)     m_rd_dat <= '0;
        else if (acc_c.rd) m_rd_dat <= rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en, rd_en0, wr_en0;
  logic [31:0] m_addr, m_wr_dat, m_addr0, m_wr_dat0;
  logic [3:0]  byte_en, byte_en0;
  logic [31:0] m_rd_dat, m_rd_dat0;
  logic        ready, err, ready0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .m_addr(m_addr),
    .m_wr_dat(m_wr_dat), .byte_en(byte_en), .m_rd_dat(m_rd_dat), .ready(ready), .err(err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .rd_en(rd_en0), .wr_en(wr_en0), .m_addr(m_addr0),
    .m_wr_dat(m_wr_dat0), .byte_en(byte_en0), .m_rd_dat(m_rd_dat0), .ready(ready0), .err(err0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Park request inputs at junk values so stray captures show up
  task automatic idle_inputs();
    rd_en  = 1'b0; wr_en  = 1'b0; m_addr  = 32'hFFFF_FFF3; m_wr_dat  = 32'h5A5A_5A5A; byte_en  = 4'hF;
    rd_en0 = 1'b0; wr_en0 = 1'b0; m_addr0 = 32'hFFFF_FFF3; m_wr_dat0 = 32'h5A5A_5A5A; byte_en0 = 4'hF;
  endtask

  // One request: cyc is the cycle (1 = right after capture) in which ready is seen
  task automatic access(input bit fast, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdat, output logic e, output int cyc, output logic tail);
    @(negedge clk);
    if (fast) begin rd_en0 = r; wr_en0 = w; m_addr0 = a; m_wr_dat0 = d; byte_en0 = be; end
    else      begin rd_en  = r; wr_en  = w; m_addr  = a; m_wr_dat  = d; byte_en  = be; end
    @(posedge clk); #1;
    idle_inputs();
    cyc = 1;
    while (!(fast ? ready0 : ready) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rdat = fast ? m_rd_dat0 : m_rd_dat;
    e    = fast ? err0 : err;
    @(posedge clk); #1;
    tail = fast ? (ready0 | err0) : (ready | err);
  endtask

  task automatic do_wr(input bit fast, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic exp_err, input string tag);
    logic [31:0] rdat; logic e; int cyc; logic tail;
    access(fast, 1'b0, 1'b1, a, d, be, rdat, e, cyc, tail);
    check_eq({tag, "_lat"}, 32'(cyc), fast ? 32'd1 : 32'd3);
    check_eq({tag, "_err"}, 32'(e), 32'(exp_err));
    check_eq({tag, "_pulse"}, 32'(tail), 32'd0);
  endtask

  task automatic do_rd(input bit fast, input logic [31:0] a, input logic [31:0] exp_dat,
                       input logic exp_err, input string tag);
    logic [31:0] rdat; logic e; int cyc; logic tail;
    access(fast, 1'b1, 1'b0, a, 32'h0, 4'h0, rdat, e, cyc, tail);
    check_eq({tag, "_lat"}, 32'(cyc), fast ? 32'd1 : 32'd3);
    check_eq({tag, "_dat"}, rdat, exp_dat);
    check_eq({tag, "_err"}, 32'(e), 32'(exp_err));
    check_eq({tag, "_pulse"}, 32'(tail), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdat; logic e; int cyc; logic tail;
    logic [7:0]  pat;
    logic        seen;

    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready",  32'(ready),  32'd0);
    check_eq("rst_err",    32'(err),    32'd0);
    check_eq("rst_rdat",   m_rd_dat,    32'd0);
    check_eq("rst_ready0", 32'(ready0), 32'd0);
    @(negedge clk) reset = 1'b1;

    // Full write then read back
    do_wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "wr10");
    do_rd(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "rd10");

    // Partial lane write; read data register must hold across writes
    do_wr(0, 32'h10, 32'h0000_00AA, 4'h1, 1'b0, "wr10_b0");
    check_eq("rdat_hold", m_rd_dat, 32'hDEAD_BEEF);
    do_rd(0, 32'h10, 32'hDEAD_BEAA, 1'b0, "rd10_b0");

    // Empty byte mask writes nothing and is not an error
    do_wr(0, 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0, "wr10_be0");
    do_rd(0, 32'h10, 32'hDEAD_BEAA, 1'b0, "rd10_be0");

    // Middle lanes
    do_wr(0, 32'h14, 32'h1122_3344, 4'hF, 1'b0, "wr14");
    do_wr(0, 32'h14, 32'hAABB_CCDD, 4'h6, 1'b0, "wr14_mid");
    do_rd(0, 32'h14, 32'h11BB_CC44, 1'b0, "rd14");

    // Error cases: misaligned, out of range, neither may touch the array
    do_rd(0, 32'h12,  32'h0, 1'b1, "rd_mis");
    do_rd(0, 32'h400, 32'h0, 1'b1, "rd_oob");
    do_wr(0, 32'h0,   32'h0102_0304, 4'hF, 1'b0, "wr00");
    do_wr(0, 32'h400, 32'hFFFF_FFFF, 4'hF, 1'b1, "wr_oob");
    do_wr(0, 32'h12,  32'hFFFF_FFFF, 4'hF, 1'b1, "wr_mis");
    do_rd(0, 32'h0,   32'h0102_0304, 1'b0, "rd00_after");
    do_rd(0, 32'h10,  32'hDEAD_BEAA, 1'b0, "rd10_after");

    // Simultaneous read and write is an error and leaves memory intact
    do_wr(0, 32'h20, 32'h0BAD_F00D, 4'hF, 1'b0, "wr20");
    access(0, 1'b1, 1'b1, 32'h20, 32'h5555_5555, 4'hF, rdat, e, cyc, tail);
    check_eq("both_err",  32'(e), 32'd1);
    check_eq("both_rdat", rdat,   32'd0);
    do_rd(0, 32'h20, 32'h0BAD_F00D, 1'b0, "rd20");

    // Held rd_en: next capture only once back in IDLE (ready at edges 2 and 6)
    @(negedge clk);
    rd_en = 1'b1; m_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      pat[k] = ready;
    end
    idle_inputs();
    check_eq("held_pattern", 32'(pat), 32'h44);
    check_eq("held_rdat", m_rd_dat, 32'h0BAD_F00D);
    repeat (2) @(posedge clk);

    // Reset during WAIT of a write aborts it
    do_wr(0, 32'h30, 32'h1234_5678, 4'hF, 1'b0, "wr30");
    @(negedge clk);
    wr_en = 1'b1; m_addr = 32'h30; m_wr_dat = 32'hCAFE_F00D; byte_en = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(ready), 32'd0);
    check_eq("midrst_rdat",  m_rd_dat,   32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | ready | err;
    end
    check_eq("midrst_quiet", 32'(seen), 32'd0);
    @(negedge clk) reset = 1'b1;
    do_rd(0, 32'h30, 32'h1234_5678, 1'b0, "rd30");

    // Zero-wait instance
    do_wr(1, 32'h10, 32'h600D_CAFE, 4'hF, 1'b0, "f_wr10");
    do_rd(1, 32'h10, 32'h600D_CAFE, 1'b0, "f_rd10");
    do_rd(1, 32'h12, 32'h0,         1'b1, "f_rd_mis");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
